// File: rtl/acsu_pipe.sv
// Registered add-compare-select stage for a rate-1/2 Viterbi decoder with
// 2^(K-1) states, saturating path metrics and per-step normalisation.
module acsu_pipe #(
    parameter int unsigned K       = 3,
    parameter int unsigned BM_W    = 2,
    parameter int unsigned PM_W    = 8,
    parameter int unsigned INIT_PM = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic                               start_i,
    input  logic [2*(1<<(K-1))*BM_W-1:0]       bm_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [(1<<(K-1))-1:0]              dec_bits_o,
    output logic [K-2:0]                       best_state_o,
    output logic [(1<<(K-1))*PM_W-1:0]         pm_o
);

    localparam int unsigned NS = 1 << (K - 1);
    localparam int unsigned SW = K - 1;
    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);
    localparam logic [PM_W-1:0] PM_MAX = '1;

    logic [PM_W-1:0] pm_q   [NS];
    logic [PM_W-1:0] pm_d   [NS];
    logic [PM_W-1:0] base   [NS];
    logic [PM_W:0]   cand0  [NS];
    logic [PM_W:0]   cand1  [NS];
    logic [PM_W-1:0] sat0   [NS];
    logic [PM_W-1:0] sat1   [NS];
    logic [PM_W-1:0] sel    [NS];
    logic [SW-1:0]   pred0  [NS];
    logic [SW-1:0]   pred1  [NS];
    logic [PM_W-1:0] min_pm;
    logic [NS-1:0]   dec_new, dec_q, dec_d;
    logic [SW-1:0]   best_new, best_q, best_d;
    logic            out_valid_q, out_valid_d;
    logic            acc;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign acc        = in_valid_i && in_ready_o;

    always_comb begin
        dec_new  = '0;
        best_new = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            base[j] = start_i ? ((j == 0) ? '0 : INIT_V) : pm_q[j];
        end
        for (int unsigned j = 0; j < NS; j++) begin
            // Shifting the state left by one and truncating gives p0 = (2j) mod NS.
            pred0[j] = SW'(j << 1);
            pred1[j] = pred0[j] | SW'(1);
            cand0[j] = {1'b0, base[pred0[j]]} + (PM_W+1)'(bm_i[(2*j)*BM_W +: BM_W]);
            cand1[j] = {1'b0, base[pred1[j]]} + (PM_W+1)'(bm_i[(2*j+1)*BM_W +: BM_W]);
            sat0[j]  = cand0[j][PM_W] ? PM_MAX : cand0[j][PM_W-1:0];
            sat1[j]  = cand1[j][PM_W] ? PM_MAX : cand1[j][PM_W-1:0];
            if (sat0[j] <= sat1[j]) begin
                sel[j]     = sat0[j];
                dec_new[j] = 1'b0;
            end else begin
                sel[j]     = sat1[j];
                dec_new[j] = 1'b1;
            end
        end
        // Strict compare keeps the lowest index among equal minima.
        min_pm = sel[0];
        for (int unsigned j = 1; j < NS; j++) begin
            if (sel[j] < min_pm) begin
                min_pm   = sel[j];
                best_new = SW'(j);
            end
        end
        for (int unsigned j = 0; j < NS; j++) begin
            pm_d[j] = acc ? (sel[j] - min_pm) : pm_q[j];
        end
        dec_d       = acc ? dec_new : dec_q;
        best_d      = acc ? best_new : best_q;
        out_valid_d = acc ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned j = 0; j < NS; j++) begin
                pm_q[j] <= (j == 0) ? '0 : INIT_V;
            end
            dec_q       <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NS; j++) begin
                pm_q[j] <= pm_d[j];
            end
            dec_q       <= dec_d;
            best_q      <= best_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar g = 0; g < NS; g++) begin : g_pm
        assign pm_o[g*PM_W +: PM_W] = pm_q[g];
    end

    assign out_valid_o  = out_valid_q;
    assign dec_bits_o   = dec_q;
    assign best_state_o = best_q;

endmodule

// File: tb/tb_acsu_pipe.sv
// Bench for acsu_pipe: two instances (K=3/INIT 64 and K=4/INIT 254) checked
// against an integer trellis model, with directed reset, tie, stall and saturation steps.
module tb_acsu_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n, a_valid, a_start, a_ordy, a_rdy, a_ov;
    logic [15:0] a_bm;
    logic [3:0]  a_dec;
    logic [1:0]  a_best;
    logic [31:0] a_pm;

    logic        b_rst_n, b_valid, b_start, b_ordy, b_rdy, b_ov;
    logic [31:0] b_bm;
    logic [7:0]  b_dec;
    logic [2:0]  b_best;
    logic [63:0] b_pm;

    acsu_pipe #(.K(3), .BM_W(2), .PM_W(8), .INIT_PM(64)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .in_valid_i(a_valid), .in_ready_o(a_rdy),
        .start_i(a_start), .bm_i(a_bm), .out_valid_o(a_ov), .out_ready_i(a_ordy),
        .dec_bits_o(a_dec), .best_state_o(a_best), .pm_o(a_pm)
    );

    acsu_pipe #(.K(4), .BM_W(2), .PM_W(8), .INIT_PM(254)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .in_valid_i(b_valid), .in_ready_o(b_rdy),
        .start_i(b_start), .bm_i(b_bm), .out_valid_o(b_ov), .out_ready_i(b_ordy),
        .dec_bits_o(b_dec), .best_state_o(b_best), .pm_o(b_pm)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference state per instance: metrics as plain integers.
    int mpm    [2][8];
    bit m_ov   [2];
    int m_dec  [2];
    int m_best [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset(input int u);
        int init;
        init = (u == 0) ? 64 : 254;
        for (int j = 0; j < 8; j++) mpm[u][j] = (j == 0) ? 0 : init;
        m_ov[u]   = 1'b0;
        m_dec[u]  = 0;
        m_best[u] = 0;
    endtask

    task automatic model_step(input int u, input bit st, input logic [31:0] bmv);
        int ns, init, p0, c0, c1, m, dec, best;
        int base [8];
        int sel  [8];
        ns   = (u == 0) ? 4 : 8;
        init = (u == 0) ? 64 : 254;
        for (int j = 0; j < ns; j++) base[j] = st ? ((j == 0) ? 0 : init) : mpm[u][j];
        dec = 0;
        for (int j = 0; j < ns; j++) begin
            p0 = (2 * j) % ns;
            c0 = base[p0] + int'(bmv[4*j +: 2]);
            c1 = base[p0 + 1] + int'(bmv[4*j + 2 +: 2]);
            if (c0 > 255) c0 = 255;
            if (c1 > 255) c1 = 255;
            if (c0 <= c1) sel[j] = c0;
            else begin
                sel[j] = c1;
                dec    = dec | (1 << j);
            end
        end
        m = 256;
        best = 0;
        for (int j = 0; j < ns; j++) begin
            if (sel[j] < m) begin
                m    = sel[j];
                best = j;
            end
        end
        for (int j = 0; j < ns; j++) mpm[u][j] = sel[j] - m;
        m_dec[u]  = dec;
        m_best[u] = best;
    endtask

    function automatic logic [63:0] exp_pm(input int u);
        logic [63:0] r;
        int ns;
        r  = '0;
        ns = (u == 0) ? 4 : 8;
        for (int j = 0; j < ns; j++) r[j*8 +: 8] = 8'(mpm[u][j]);
        return r;
    endfunction

    // One clock of stimulus on instance u, followed by checks after the edge.
    task automatic cycle(input int u, input bit rst_n, input bit v, input bit st,
                         input logic [31:0] bmv, input bit ordy);
        bit          exp_rdy, acc;
        logic        o_rdy, o_ov;
        logic [7:0]  o_dec;
        logic [2:0]  o_best;
        logic [63:0] o_pm;
        if (u == 0) begin
            a_rst_n = rst_n; a_valid = v; a_start = st; a_bm = bmv[15:0]; a_ordy = ordy;
        end else begin
            b_rst_n = rst_n; b_valid = v; b_start = st; b_bm = bmv; b_ordy = ordy;
        end
        #2;
        o_rdy   = (u == 0) ? a_rdy : b_rdy;
        exp_rdy = !m_ov[u] || ordy;
        chk("in_ready", 64'(o_rdy), 64'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset(u);
        else begin
            if (acc) model_step(u, st, bmv);
            m_ov[u] = acc ? 1'b1 : (ordy ? 1'b0 : m_ov[u]);
        end
        if (u == 0) begin
            o_ov = a_ov; o_dec = 8'(a_dec); o_best = 3'(a_best); o_pm = 64'(a_pm);
        end else begin
            o_ov = b_ov; o_dec = b_dec; o_best = b_best; o_pm = b_pm;
        end
        chk("out_valid", 64'(o_ov), 64'(m_ov[u]));
        chk("dec_bits", 64'(o_dec), 64'(m_dec[u]));
        chk("best_state", 64'(o_best), 64'(m_best[u]));
        chk("pm", o_pm, exp_pm(u));
    endtask

    initial begin
        a_rst_n = 1'b0; a_valid = 1'b0; a_start = 1'b0; a_bm = '0; a_ordy = 1'b1;
        b_rst_n = 1'b0; b_valid = 1'b0; b_start = 1'b0; b_bm = '0; b_ordy = 1'b1;
        model_reset(0);
        model_reset(1);

        // Instance A: reset state, then the zero-metric start step.
        cycle(0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("reset_pm", 64'(a_pm), 64'h4040_4000);
        cycle(0, 1'b1, 1'b1, 1'b1, '0, 1'b1);
        chk("first_pm", 64'(a_pm), 64'h4000_4000);
        chk("first_dec", 64'(a_dec), 64'h0);
        cycle(0, 1'b1, 1'b0, 1'b0, '0, 1'b1);

        // State 1 candidate from p0 pushed above the p1 candidate: dec bit 1 set.
        cycle(0, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1);
        chk("dec_bit1", 64'(a_dec), 64'h2);
        chk("dec_bit1_pm", 64'(a_pm), 64'h4000_4000);

        // Full-rate random stream, frame restart on step 20.
        for (int i = 0; i < 40; i++)
            cycle(0, 1'b1, 1'b1, (i == 20), 32'($urandom), 1'b1);

        // Random valid/ready gaps, occasional start.
        for (int i = 0; i < 40; i++)
            cycle(0, 1'b1, ($urandom_range(3) != 0), ($urandom_range(7) == 0),
                  32'($urandom), ($urandom_range(2) != 0));

        // Backpressure: five stalled cycles with valid (and start) asserted, then release.
        cycle(0, 1'b1, 1'b1, 1'b0, 32'($urandom), 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(0, 1'b1, 1'b1, (i == 2), 32'($urandom), 1'b0);
        cycle(0, 1'b1, 1'b1, 1'b0, 32'($urandom), 1'b1);
        cycle(0, 1'b1, 1'b1, 1'b0, 32'($urandom), 1'b1);

        // Reset in the middle of streaming discards the concurrent step.
        for (int i = 0; i < 3; i++)
            cycle(0, 1'b1, 1'b1, 1'b0, 32'($urandom), 1'b1);
        cycle(0, 1'b0, 1'b1, 1'b0, 32'($urandom), 1'b1);
        chk("midrst_pm", 64'(a_pm), 64'h4040_4000);
        for (int i = 0; i < 5; i++)
            cycle(0, 1'b1, 1'b1, 1'b0, 32'($urandom), 1'b1);

        // Instance B (K=4, INIT 254): saturation on state 1.
        cycle(1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1, 1'b1, 1'b1, 1'b1, 32'h0000_00F0, 1'b1);
        chk("sat_pm1", 64'(b_pm[15:8]), 64'hFF);
        chk("sat_dec", 64'(b_dec), 64'h0);
        for (int i = 0; i < 40; i++)
            cycle(1, 1'b1, ($urandom_range(4) != 0), ($urandom_range(15) == 0),
                  32'($urandom), ($urandom_range(3) != 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
